// File: rtl/soc_mmio_pkg.sv
// Shared MMIO constants and types for the UART transmitter register block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package soc_mmio_pkg;

   // Register byte offsets inside the UART window
   localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
   localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;

   // Address bit that selects between TXDATA and STATUS
   localparam int UART_OFS_BIT = 2;

   // STATUS register bit positions
   localparam int UART_ST_BUSY      = 0;
   localparam int UART_ST_FULL      = 1;
   localparam int UART_ST_EMPTY     = 2;
   localparam int UART_ST_OVF       = 3;
   localparam int UART_ST_LEVEL_LSB = 4;
   localparam int UART_ST_LEVEL_W   = 4;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// TX byte queue: FIFO_DEPTH-entry FIFO with UART_TX_FIFO_EN, else a one-byte holding register.
// Latency: pushed byte visible on rdata the cycle after the push; rdata is combinational from storage.
// Backpressure: push while full is accepted only if a pop happens the same cycle, otherwise dropped.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [7:0]                   wdata,
   output logic [7:0]                   rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_DEPTH):0]  level
);

   localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_FIFO_EN

   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic        push_ok, pop_ok;

   // Pointer arithmetic with one extra wrap bit distinguishes full from empty
   always_comb begin
      empty   = (wr_q == rd_q);
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      level   = wr_q - rd_q;
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      wr_d    = wr_q + {{AW{1'b0}}, push_ok};
      rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
      rdata   = mem_q[rd_q[AW-1:0]];
      mem_d   = mem_q;
      if (push_ok) begin
         mem_d[wr_q[AW-1:0]] = wdata;
      end
   end

   // Pointers reset so queued bytes are discarded
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`else

   logic       vld_q, vld_d;
   logic [7:0] dat_q, dat_d;
   logic       push_ok;

   // Single holding register: full means the byte is still waiting
   always_comb begin
      full    = vld_q;
      empty   = ~vld_q;
      level   = {{AW{1'b0}}, vld_q};
      rdata   = dat_q;
      push_ok = push & (~vld_q | pop);
      vld_d   = push_ok | (vld_q & ~pop);
      dat_d   = push_ok ? wdata : dat_q;
   end

   // Holding register state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

`endif

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter (TXDATA/STATUS); macro UART_TX_FIFO_EN selects the deep queue.
// Latency: registered bus read one cycle after address; frame starts two cycles after the TXDATA write when idle.
// Backpressure: none on the bus; writes to a full queue are dropped and set sticky ovf.
module uart_tx_mmio
   import soc_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFE0,
   parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFE7,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAddress,
   input  logic [31:0] memWriteData,
   input  logic        memWrite,
   input  logic [3:0]  byteMask,
   output logic [31:0] memReadData,
   output logic        tx
);

   localparam int          LW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   logic           hit, sel_status, push_req, clr_req, pop, drop, busy;
   logic           fifo_full, fifo_empty;
   logic [7:0]     fifo_rdata;
   logic [LW-1:0]  fifo_level;
   logic [31:0]    status_word;

   uart_tx_state_t state_q, state_d;
   logic [15:0]    baud_q, baud_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           ovf_q, ovf_d;
   logic [31:0]    rdata_q, rdata_d;

   logic           unused_bits;
   assign unused_bits = ^{memWriteData[31:8], byteMask[3:1]};

   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .wdata (memWriteData[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Bus decode, overflow flag and STATUS composition
   always_comb begin
      hit        = (memAddress >= BASE_MEMORY) && (memAddress <= TOP_MEMORY);
      sel_status = memAddress[UART_OFS_BIT];
      push_req   = memWrite & hit & ~sel_status & byteMask[0];
      clr_req    = memWrite & hit & sel_status & byteMask[0] & memWriteData[UART_ST_OVF];
      pop        = (state_q == UART_IDLE) & ~fifo_empty;
      drop       = push_req & fifo_full & ~pop;
      // A drop in the same cycle as a clear leaves ovf set
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_req) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      status_word = '0;
      status_word[UART_ST_LEVEL_LSB +: UART_ST_LEVEL_W] = 4'(fifo_level);
      status_word[UART_ST_OVF]   = ovf_q;
      status_word[UART_ST_EMPTY] = fifo_empty;
      status_word[UART_ST_FULL]  = fifo_full;
      status_word[UART_ST_BUSY]  = busy;
      rdata_d = (hit && sel_status) ? status_word : '0;
   end

   // Next-state logic: framing FSM plus baud counter, bit index and shift byte
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      unique case (state_q)
         UART_IDLE: begin
            baud_d = '0;
            idx_d  = '0;
            if (!fifo_empty) begin
               state_d = UART_START;
               shift_d = fifo_rdata;
            end
         end
         UART_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = UART_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         UART_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               idx_d  = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = UART_STOP;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         UART_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               state_d = UART_IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = UART_IDLE;
      endcase
   end

   // Outputs: tx is computed from the next state so the line flop tracks state_q exactly
   always_comb begin
      busy = (state_q != UART_IDLE);
      unique case (state_d)
         UART_START: tx_d = 1'b0;
         UART_DATA:  tx_d = shift_d[idx_d];
         default:    tx_d = 1'b1;
      endcase
   end

   // State register; reset aborts any frame and returns the line high at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UART_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
      end
   end

   assign memReadData = rdata_q;
   assign tx          = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: bus writes feed an expected-byte queue, a line monitor decodes frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_mmio;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
`ifdef UART_TX_FIFO_EN
   localparam int CAP = DEPTH;
`else
   localparam int CAP = 1;
`endif

   localparam logic [31:0] A_TXDATA = 32'hFFFF_FFE0;
   localparam logic [31:0] A_STATUS = 32'hFFFF_FFE4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] memAddress = '0;
   logic [31:0] memWriteData = '0;
   logic        memWrite = 1'b0;
   logic [3:0]  byteMask = '0;
   logic [31:0] memReadData;
   logic        tx;

   int errors = 0;
   int checks = 0;
   logic [7:0] sb[$];
   int frames_started = 0;
   int frames_done = 0;
   int last_gap = 0;

   uart_tx_mmio #(
      .BASE_MEMORY (32'hFFFF_FFE0),
      .TOP_MEMORY  (32'hFFFF_FFE7),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .memAddress  (memAddress),
      .memWriteData(memWriteData),
      .memWrite    (memWrite),
      .byteMask    (byteMask),
      .memReadData (memReadData),
      .tx          (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] st(input int lvl, input bit ovf, input bit emp, input bit ful, input bit bsy);
      return {24'b0, 4'(lvl), ovf, emp, ful, bsy};
   endfunction

   // Called at posedge+1; returns at posedge+1 after the write edge
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      memAddress   = a;
      memWriteData = d;
      byteMask     = m;
      memWrite     = 1'b1;
      @(posedge clk); #1;
      memWrite     = 1'b0;
   endtask

   task automatic read_status(output logic [31:0] v);
      memAddress = A_STATUS;
      @(posedge clk); #1;
      v = memReadData;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((sb.size() != 0 || tx !== 1'b1) && t < 4000) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (4) begin @(posedge clk); #1; end
      check(name, 32'(sb.size()), 32'd0);
   endtask

   // Line monitor: decode each frame and compare against the head of the expected queue
   initial begin
      int gap;
      logic [9:0] ideal;
      logic [7:0] got;
      logic [7:0] exp;
      int wave_err;
      bit have, aborted;
      gap = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            gap = 0;
            continue;
         end
         if (tx === 1'b1) begin
            gap++;
            continue;
         end
         last_gap = gap;
         gap = 0;
         frames_started++;
         have = (sb.size() > 0);
         exp = have ? sb[0] : 8'h00;
         ideal = {1'b1, exp, 1'b0};
         wave_err = 0;
         got = '0;
         aborted = 1'b0;
         for (int c = 0; c < 10 * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (reset) begin
               aborted = 1'b1;
               break;
            end
            if (tx !== ideal[c / CPB]) wave_err++;
            if ((c % CPB) == (CPB / 2) && (c / CPB) >= 1 && (c / CPB) <= 8) got[c / CPB - 1] = tx;
         end
         if (!aborted) begin
            if (!have) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got 0x%02h expected no frame", got);
            end else begin
               check("frame_byte", 32'(got), 32'(sb.pop_front()));
               check("frame_wave", 32'(wave_err), 32'd0);
            end
            frames_done++;
         end
      end
   end

   // Absolute time bound on the whole run
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  b;
      int busy_cnt, fs, fd, n_valid, t;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_rdata", memReadData, 32'd0);
      reset = 1'b0;
      read_status(v);
      check("idle_status", v, st(0, 0, 1, 0, 0));

      // Read path: miss, one-cycle latency, TXDATA reads zero
      memAddress = 32'hFFFF_FFF0;
      @(posedge clk); #1;
      check("miss_read", memReadData, 32'd0);
      memAddress = A_STATUS;
      @(negedge clk);
      check("read_before_edge", memReadData, 32'd0);
      @(posedge clk); #1;
      check("read_n_plus_1", memReadData, st(0, 0, 1, 0, 0));
      memAddress = A_TXDATA;
      @(posedge clk); #1;
      check("txdata_read", memReadData, 32'd0);

      // Single byte and busy duration
      sb.push_back(8'h55);
      bus_write(A_TXDATA, 32'h0000_0055, 4'hF);
      memAddress = A_STATUS;
      busy_cnt = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (memReadData[0]) busy_cnt++;
      end
      check("busy_cycles", 32'(busy_cnt), 32'(10 * CPB));
      wait_drain("single_drain");

      // Back-to-back frames
      fs = frames_started;
      sb.push_back(8'hA5);
      sb.push_back(8'h3C);
      bus_write(A_TXDATA, 32'h0000_00A5, 4'h1);
      bus_write(A_TXDATA, 32'h0000_003C, 4'h1);
      t = 0;
      while (frames_started < fs + 2 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      check("b2b_started", 32'(frames_started - fs), 32'd2);
      read_status(v);
      check("b2b_empty_status", v, st(0, 0, 1, 0, 1));
      wait_drain("b2b_drain");
      check("b2b_gap", 32'(last_gap), 32'd1);

      // Overflow: fill the queue while the first byte is on the line
      for (int i = 0; i <= CAP; i++) begin
         b = 8'($urandom);
         sb.push_back(b);
         bus_write(A_TXDATA, {24'h0, b}, 4'h1);
      end
      read_status(v);
      check("ovf_full_status", v, st(CAP, 0, 0, 1, 1));
      bus_write(A_TXDATA, 32'h0000_00E7, 4'h1);
      read_status(v);
      check("ovf_set_status", v, st(CAP, 1, 0, 1, 1));
      bus_write(A_STATUS, 32'h0000_0007, 4'h1);
      bus_write(A_STATUS, 32'h0000_0008, 4'h0);
      read_status(v);
      check("ovf_hold_status", v, st(CAP, 1, 0, 1, 1));
      bus_write(A_STATUS, 32'h0000_0008, 4'h1);
      read_status(v);
      check("ovf_clear_status", v, st(CAP, 0, 0, 1, 1));
      wait_drain("ovf_drain");
      read_status(v);
      check("post_drain_status", v, st(0, 0, 1, 0, 0));

      // Random traffic mixed with writes that must be ignored
      fd = frames_done;
      n_valid = 0;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            if (sb.size() < CAP) begin
               b = 8'($urandom);
               sb.push_back(b);
               n_valid++;
               bus_write(A_TXDATA, {24'($urandom) , b}, 4'($urandom_range(0, 15)) | 4'h1);
            end
         end else begin
            case ($urandom_range(0, 2))
               0: bus_write(($urandom_range(0, 1) == 0) ? 32'hFFFF_FFE8 : 32'hFFFF_FFD0, $urandom, 4'hF);
               1: bus_write(A_STATUS, $urandom & 32'hFFFF_FFF7, 4'hF);
               default: bus_write(A_TXDATA, $urandom, 4'($urandom_range(0, 7)) << 1);
            endcase
         end
         repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
      end
      wait_drain("random_drain");
      check("random_frames", 32'(frames_done - fd), 32'(n_valid));

      // Mid-frame reset during data bit 3, with a second byte queued
      sb.push_back(8'h00);
      sb.push_back(8'hFF);
      bus_write(A_TXDATA, 32'h0000_0000, 4'h1);
      bus_write(A_TXDATA, 32'h0000_00FF, 4'h1);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (tx !== 1'b0 && t < 500);
      check("mid_start_seen", 32'(tx), 32'd0);
      repeat (4 * CPB + 1) @(negedge clk);
      check("pre_reset_tx", 32'(tx), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("reset_tx_immediate", 32'(tx), 32'd1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      read_status(v);
      check("post_reset_status", v, st(0, 0, 1, 0, 0));
      fs = frames_started;
      repeat (200) begin @(posedge clk); #1; end
      check("no_residual_frame", 32'(frames_started - fs), 32'd0);
      check("idle_tx_after_reset", 32'(tx), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
